// File: rtl/serial_add_engine_if.sv
// Handshake/result bundle between an add requester and the bit-serial add engine.
// The master drives the request; the slave returns status and the serial sum stream.
interface serial_add_engine_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             sum_bit;
   logic             sum_shift;
   logic             done;
   logic             cout;
   logic             overflow;

   modport master (
      output start, a, b, cin,
      input  busy, sum_bit, sum_shift, done, cout, overflow
   );

   modport slave (
      input  start, a, b, cin,
      output busy, sum_bit, sum_shift, done, cout, overflow
   );
endinterface

// File: rtl/serial_add_engine.sv
// Bit-serial adder and sequencer: captures A, B and cin, then emits one full-adder
// sum bit per cycle LSB-first into a downstream SIPO, finishing with carry/overflow flags.
module serial_add_engine #(
   parameter int WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   serial_add_engine_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_shift;
   logic             r_done;
   logic             r_cout;
   logic             r_ovf;

   logic w_maj;
   logic w_last;

   assign w_maj  = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // sum_bit is gated so the SIPO sees a clean 0 whenever no shift is in progress.
   assign bus.sum_bit   = r_shift & (r_a_sr[0] ^ r_b_sr[0] ^ r_carry);
   assign bus.sum_shift = r_shift;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.cout      = r_cout;
   assign bus.overflow  = r_ovf;

   // NOTE: all state updates use non-blocking assignments so every register samples
   // pre-edge values; w_maj is therefore the carry computed from the current bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_shift <= 1'b0;
         r_done  <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a_sr  <= bus.a;
                  r_b_sr  <= bus.b;
                  r_carry <= bus.cin;
                  r_cnt   <= '0;
                  r_cout  <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_shift <= 1'b1;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_carry <= w_maj;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  // r_carry here is the carry into the MSB, so this is signed overflow.
                  r_cout  <= w_maj;
                  r_ovf   <= r_carry ^ w_maj;
                  r_shift <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_shift <= 1'b0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_engine.sv
// Directed bench for serial_add_engine: models the downstream SIPO and scores each
// add against a reference A+B+cin captured when the request is driven.
module tb_serial_add_engine;
   localparam int WIDTH = 32;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   logic clk;
   logic rst;
   logic [WIDTH-1:0] sipo;
   exp_t sb[$];
   int vectors;
   int miscompares;

   serial_add_engine_if #(.WIDTH(WIDTH)) sif ();

   serial_add_engine #(.WIDTH(WIDTH)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream SIPO model: LSB-first stream lands bit 0 at bit 0 after WIDTH shifts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sipo <= '0;
      else if (sif.sum_shift) sipo <= {sif.sum_bit, sipo[WIDTH-1:1]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin);
      exp_t e;
      logic [WIDTH:0] full;
      full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      e.sum  = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
      return e;
   endfunction

   // Drives a request at the negedge; returns just after the edge that samples it.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input bit push);
      @(negedge clk);
      sif.start = 1'b1;
      sif.a     = a;
      sif.b     = b;
      sif.cin   = cin;
      if (push) sb.push_back(model(a, b, cin));
      @(posedge clk);
   endtask

   // Called right after the accepting edge; cycle k is the negedge after edge E0+k-1.
   task automatic wait_result(input bit keep_start, input int poke_cycle);
      int   done_cycle;
      int   shifts;
      exp_t e;
      done_cycle = 0;
      shifts     = 0;
      for (int k = 1; k <= 60 && done_cycle == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (!keep_start) sif.start = 1'b0;
            sif.a = $urandom;
            sif.b = $urandom;
            check("busy_in_shift", 32'(sif.busy), 32'd1);
            check("flags_cleared_on_start", {30'd0, sif.cout, sif.overflow}, 32'd0);
         end
         if (poke_cycle != 0 && k == poke_cycle) begin
            sif.start = 1'b1;
            sif.a     = 32'hAAAA_AAAA;
         end
         if (poke_cycle != 0 && k == poke_cycle + 1) sif.start = 1'b0;
         if (sif.sum_shift) shifts++;
         if (sif.done) done_cycle = k;
      end
      if (done_cycle == 0) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         check("done_latency", 32'(done_cycle), 32'(WIDTH + 1));
         check("shift_cycles", 32'(shifts), 32'(WIDTH));
         if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            check("sipo_sum", sipo, e.sum);
            check("cout", 32'(sif.cout), 32'(e.cout));
            check("overflow", 32'(sif.overflow), 32'(e.ovf));
         end
      end
   endtask

   initial begin
      int done_seen;
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      sif.start   = 1'b0;
      sif.a       = '0;
      sif.b       = '0;
      sif.cin     = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(sif.busy), 32'd0);
      check("rst_outputs", {27'd0, sif.sum_bit, sif.sum_shift, sif.done, sif.cout, sif.overflow},
            32'd0);
      check("rst_sipo", sipo, 32'd0);
      rst = 1'b0;

      issue(32'd5, 32'd3, 1'b0, 1'b1);
      wait_result(1'b0, 0);
      issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
      wait_result(1'b0, 0);
      // cout must persist through the following idle cycle.
      @(negedge clk);
      check("cout_held", 32'(sif.cout), 32'd1);
      issue(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
      wait_result(1'b0, 0);
      issue(32'd0, 32'd0, 1'b1, 1'b1);
      wait_result(1'b0, 0);
      issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
      wait_result(1'b0, 0);

      // start pulsed mid-shift is ignored.
      issue(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b1);
      wait_result(1'b0, 10);

      // Held start: second add is accepted after one idle cycle.
      issue(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b1);
      wait_result(1'b1, 0);
      sif.a   = 32'h4000_0000;
      sif.b   = 32'h4000_0000;
      sif.cin = 1'b0;
      sb.push_back(model(32'h4000_0000, 32'h4000_0000, 1'b0));
      @(negedge clk);
      check("idle_gap", {30'd0, sif.busy, sif.sum_shift}, 32'd0);
      @(posedge clk);
      wait_result(1'b0, 0);

      // Reset mid-operation aborts immediately.
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      repeat (12) @(negedge clk);
      sif.start = 1'b0;
      rst = 1'b1;
      #1;
      check("abort_outputs", {28'd0, sif.busy, sif.sum_shift, sif.cout, sif.overflow}, 32'd0);
      check("abort_sipo", sipo, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (sif.done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);

      issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
      wait_result(1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
